// File: rtl/mmio_timer.sv
// Memory-mapped 64-bit machine timer: prescaled free-running counter, 64-bit
// compare, level interrupt, sticky W1C match flag, optional auto-reload.
`timescale 1ns/1ps
module mmio_timer #(
  parameter logic [31:0] BASE_ADDR = 32'h1000_0000,
  parameter int unsigned PRESC_W   = 16
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        we,
  input  logic [3:0]  byteEnable,
  input  logic [31:0] a,
  input  logic [31:0] wd,
  output logic [31:0] rd,
  output logic        hit,
  output logic        irq
);
  localparam logic [2:0] OFF_MTIME_LO = 3'd0;
  localparam logic [2:0] OFF_MTIME_HI = 3'd1;
  localparam logic [2:0] OFF_CMP_LO   = 3'd2;
  localparam logic [2:0] OFF_CMP_HI   = 3'd3;
  localparam logic [2:0] OFF_CTRL     = 3'd4;
  localparam logic [2:0] OFF_PRESC    = 3'd5;
  localparam logic [2:0] OFF_STATUS   = 3'd6;

  logic [63:0]        mtime_q, mtime_d;
  logic [63:0]        mtimecmp_q, mtimecmp_d;
  logic [2:0]         ctrl_q, ctrl_d;
  logic [PRESC_W-1:0] presc_q, presc_d;
  logic [PRESC_W-1:0] pcnt_q, pcnt_d;
  logic               status_q, status_d;

  logic [2:0]  off_s;
  logic        wr_s;
  logic        match_s;
  logic        tick_s;
  logic        w1c_s;
  logic [31:0] presc_ext_s;
  logic [31:0] reg_s;
  logic [31:0] wmerge_s;
  logic        unused_s;

  assign unused_s = ^a[1:0];

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_v,
                                              input logic [31:0] new_v,
                                              input logic [3:0]  be);
    logic [31:0] res;
    for (int i = 0; i < 4; i++) begin
      res[8*i +: 8] = be[i] ? new_v[8*i +: 8] : old_v[8*i +: 8];
    end
    return res;
  endfunction

  // Decode, compare, interrupt and register readback from current state.
  always_comb begin
    hit     = (a[31:5] == BASE_ADDR[31:5]);
    off_s   = a[4:2];
    wr_s    = we & hit & (|byteEnable);
    match_s = (mtime_q >= mtimecmp_q);
    irq     = ctrl_q[1] & match_s;
    presc_ext_s = 32'd0;
    presc_ext_s[PRESC_W-1:0] = presc_q;
    case (off_s)
      OFF_MTIME_LO: reg_s = mtime_q[31:0];
      OFF_MTIME_HI: reg_s = mtime_q[63:32];
      OFF_CMP_LO:   reg_s = mtimecmp_q[31:0];
      OFF_CMP_HI:   reg_s = mtimecmp_q[63:32];
      OFF_CTRL:     reg_s = {29'd0, ctrl_q};
      OFF_PRESC:    reg_s = presc_ext_s;
      OFF_STATUS:   reg_s = {31'd0, status_q};
      default:      reg_s = 32'd0;
    endcase
    if (hit) begin
      rd = reg_s;
    end else begin
      rd = 32'd0;
    end
    wmerge_s = merge_bytes(reg_s, wd, byteEnable);
  end

  // Next-state: prescaler tick, counter advance, then bus writes on top.
  always_comb begin
    tick_s = 1'b0;
    pcnt_d = pcnt_q;
    if (ctrl_q[0]) begin
      if (pcnt_q == presc_q) begin
        tick_s = 1'b1;
        pcnt_d = {PRESC_W{1'b0}};
      end else begin
        pcnt_d = pcnt_q + PRESC_W'(1'b1);
      end
    end else begin
      pcnt_d = pcnt_q;
    end

    if (tick_s) begin
      if (ctrl_q[2] & match_s) begin
        mtime_d = 64'd0;
      end else begin
        mtime_d = mtime_q + 64'd1;
      end
    end else begin
      mtime_d = mtime_q;
    end

    mtimecmp_d = mtimecmp_q;
    ctrl_d     = ctrl_q;
    presc_d    = presc_q;
    w1c_s      = 1'b0;
    if (wr_s) begin
      // A counter write replaces this cycle's tick; untouched lanes hold.
      case (off_s)
        OFF_MTIME_LO: begin
          mtime_d = {mtime_q[63:32], wmerge_s};
          pcnt_d  = {PRESC_W{1'b0}};
        end
        OFF_MTIME_HI: begin
          mtime_d = {wmerge_s, mtime_q[31:0]};
          pcnt_d  = {PRESC_W{1'b0}};
        end
        OFF_CMP_LO: mtimecmp_d = {mtimecmp_q[63:32], wmerge_s};
        OFF_CMP_HI: mtimecmp_d = {wmerge_s, mtimecmp_q[31:0]};
        OFF_CTRL:   ctrl_d = wmerge_s[2:0];
        OFF_PRESC: begin
          presc_d = wmerge_s[PRESC_W-1:0];
          pcnt_d  = {PRESC_W{1'b0}};
        end
        OFF_STATUS: w1c_s = |(byteEnable & {wd[24], wd[16], wd[8], wd[0]});
        default:    w1c_s = 1'b0;
      endcase
    end else begin
      w1c_s = 1'b0;
    end

    if (match_s) begin
      status_d = 1'b1;
    end else if (w1c_s) begin
      status_d = 1'b0;
    end else begin
      status_d = status_q;
    end
  end

  // State registers; clr overrides every other update in the cycle.
  always_ff @(posedge clk) begin
    if (clr) begin
      mtime_q    <= 64'd0;
      mtimecmp_q <= 64'hFFFF_FFFF_FFFF_FFFF;
      ctrl_q     <= 3'd0;
      presc_q    <= {PRESC_W{1'b0}};
      pcnt_q     <= {PRESC_W{1'b0}};
      status_q   <= 1'b0;
    end else begin
      mtime_q    <= mtime_d;
      mtimecmp_q <= mtimecmp_d;
      ctrl_q     <= ctrl_d;
      presc_q    <= presc_d;
      pcnt_q     <= pcnt_d;
      status_q   <= status_d;
    end
  end
endmodule
